// File: rtl/alu_share_arbiter.sv
//==============================================================================
// alu_share_arbiter: round-robin sharing of one 16-bit Hack ALU by two requesters.
// Optional grant counters enabled by macro ALU_ARB_STATS_EN.        Rev 1.0
//==============================================================================
`default_nettype none

module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] xa, xb, ya, yb, fo;

  always_comb begin
    xa  = zx ? '0 : x;
    xb  = nx ? ~xa : xa;
    ya  = zy ? '0 : y;
    yb  = ny ? ~ya : ya;
    fo  = f ? (xb + yb) : (xb & yb);
    out = no ? ~fo : fo;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
  end
endmodule

module alu_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int RR_INIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_x,
  input  logic [2*WIDTH-1:0] req_y,
  input  logic [11:0]        req_ctrl,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_out,
  output logic               rsp_zr,
  output logic               rsp_ng
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_x, op_y;
  logic [5:0]       op_ctrl;
  logic             gnt;
  logic             prio;
  logic             winner;
  logic             accept;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr, alu_ng;

  always_comb begin
    winner    = (req_valid == 2'b11) ? prio : req_valid[1];
    accept    = 1'b0;
    req_ready = 2'b00;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = winner ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are latched at accept so requesters may change buses afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_x      <= '0;
      op_y      <= '0;
      op_ctrl   <= '0;
      gnt       <= 1'b0;
      prio      <= (RR_INIT != 0);
      rsp_valid <= 2'b00;
      rsp_out   <= '0;
      rsp_zr    <= 1'b0;
      rsp_ng    <= 1'b0;
    end else begin
      if (accept) begin
        op_x    <= winner ? req_x[2*WIDTH-1:WIDTH] : req_x[WIDTH-1:0];
        op_y    <= winner ? req_y[2*WIDTH-1:WIDTH] : req_y[WIDTH-1:0];
        op_ctrl <= winner ? req_ctrl[11:6] : req_ctrl[5:0];
        gnt     <= winner;
        prio    <= ~winner;
      end
      if (state == EXEC) begin
        rsp_out   <= alu_out;
        rsp_zr    <= alu_zr;
        rsp_ng    <= alu_ng;
        rsp_valid <= gnt ? 2'b10 : 2'b01;
      end else if ((state == RESP) && rsp_ready[gnt]) begin
        rsp_valid <= 2'b00;
      end
    end
  end

  hack_alu #(.WIDTH(WIDTH)) u_alu (
    .x  (op_x),
    .y  (op_y),
    .zx (op_ctrl[5]),
    .nx (op_ctrl[4]),
    .zy (op_ctrl[3]),
    .ny (op_ctrl[2]),
    .f  (op_ctrl[1]),
    .no (op_ctrl[0]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (accept) begin
      if (!winner && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
      if (winner && (cnt1 != 16'hFFFF))  cnt1 <= cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`endif

endmodule

`default_nettype wire
